// File: rtl/mux7_rr_sched.sv
// Round-robin scheduler for a 7-input single-bit mux: registered select,
// one-hot grant and valid, with a programmable per-owner hold limit.
module mux7_rr_sched #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Req,
    output logic [2:0] Sel,
    output logic [6:0] Gnt,
    output logic       Valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_r;
    logic [2:0] owner_r;
    logic [2:0] ptr_r;
    logic [3:0] cnt_r;
    logic [2:0] sel_r;
    logic [6:0] gnt_r;
    logic       valid_r;

    logic [2:0] search_ptr_s;
    logic       release_s;
    logic       win_found_s;
    logic [2:0] win_idx_s;

    function automatic logic [2:0] inc7(input logic [2:0] v);
        if (v >= 3'd6) begin
            return 3'd0;
        end else begin
            return v + 3'd1;
        end
    endfunction

    // Circular first-set search; returns {found, index}.
    function automatic logic [3:0] find_winner(input logic [6:0] req, input logic [2:0] start);
        logic [2:0] idx;
        logic       found;
        logic [2:0] win;
        idx   = start;
        found = 1'b0;
        win   = 3'd0;
        for (int k = 0; k < 7; k++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = inc7(idx);
        end
        return {found, win};
    endfunction

    // Release decision and winner search on the sampled request vector.
    always_comb begin
        search_ptr_s = ptr_r;
        if (state_r == GRANT) begin
            search_ptr_s = inc7(owner_r);
        end else begin
            search_ptr_s = ptr_r;
        end
        release_s = (!Req[owner_r]) || (cnt_r == 4'(MAX_HOLD));
        {win_found_s, win_idx_s} = find_winner(Req, search_ptr_s);
    end

    // Scheduler state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            owner_r <= 3'd0;
            ptr_r   <= 3'd0;
            cnt_r   <= 4'd0;
            sel_r   <= 3'd0;
            gnt_r   <= 7'd0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        state_r <= GRANT;
                        owner_r <= win_idx_s;
                        cnt_r   <= 4'd1;
                        sel_r   <= win_idx_s;
                        gnt_r   <= 7'd1 << win_idx_s;
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        // Search starts just past the owner, so it only re-wins when alone.
                        ptr_r <= search_ptr_s;
                        if (win_found_s) begin
                            owner_r <= win_idx_s;
                            cnt_r   <= 4'd1;
                            sel_r   <= win_idx_s;
                            gnt_r   <= 7'd1 << win_idx_s;
                            valid_r <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            gnt_r   <= 7'd0;
                            valid_r <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= 7'd0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign Sel   = sel_r;
    assign Gnt   = gnt_r;
    assign Valid = valid_r;

endmodule

// File: tb/tb_mux7_rr_sched.sv
// Bench for mux7_rr_sched: two instances (hold 4 and hold 1) driven by the same
// requests, checked every cycle against an arithmetic reference model.
module tb_mux7_rr_sched;

    logic       clk;
    logic       rst_n;
    logic [6:0] Req;
    logic [2:0] sel4, sel1;
    logic [6:0] gnt4, gnt1;
    logic       valid4, valid1;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Reference model state, index 0 = hold 4, index 1 = hold 1
    int m_hold [2] = '{4, 1};
    int m_busy [2];
    int m_own  [2];
    int m_cnt  [2];
    int m_ptr  [2];
    int m_sel  [2];

    mux7_rr_sched #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Req(Req), .Sel(sel4), .Gnt(gnt4), .Valid(valid4)
    );
    mux7_rr_sched #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Req(Req), .Sel(sel1), .Gnt(gnt1), .Valid(valid1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    function automatic int winner(input logic [6:0] r, input int start);
        for (int k = 0; k < 7; k++) begin
            if (r[(start + k) % 7]) return (start + k) % 7;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_busy[m] = 0; m_own[m] = 0; m_cnt[m] = 0; m_ptr[m] = 0; m_sel[m] = 0;
        end
    endtask

    task automatic model_step(input logic [6:0] r);
        int w;
        for (int m = 0; m < 2; m++) begin
            if (m_busy[m] == 0) begin
                w = winner(r, m_ptr[m]);
                if (w >= 0) begin
                    m_busy[m] = 1; m_own[m] = w; m_cnt[m] = 1; m_sel[m] = w;
                end
            end else if (!r[m_own[m]] || m_cnt[m] == m_hold[m]) begin
                m_ptr[m] = (m_own[m] + 1) % 7;
                w = winner(r, m_ptr[m]);
                if (w >= 0) begin
                    m_own[m] = w; m_cnt[m] = 1; m_sel[m] = w;
                end else begin
                    m_busy[m] = 0;
                end
            end else begin
                m_cnt[m] = m_cnt[m] + 1;
            end
        end
    endtask

    function automatic int exp_gnt(input int m);
        return (m_busy[m] != 0) ? (1 << m_own[m]) : 0;
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("h4_sel",   int'(sel4),   m_sel[0]);
            check("h4_gnt",   int'(gnt4),   exp_gnt(0));
            check("h4_valid", int'(valid4), m_busy[0]);
            check("h1_sel",   int'(sel1),   m_sel[1]);
            check("h1_gnt",   int'(gnt1),   exp_gnt(1));
            check("h1_valid", int'(valid1), m_busy[1]);
        end
    end

    task automatic tick(input logic [6:0] r);
        Req = r;
        @(posedge clk);
        if (rst_n) model_step(r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] r;
        rst_n = 1'b0;
        Req   = 7'd0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset state and asynchronous reset mid-grant
        check("rst_sel", int'(sel4), 0);
        check("rst_valid", int'(valid4), 0);
        tick(7'b0001000);
        check("t1_pre_sel", int'(sel4), 3);
        check("t1_pre_valid", int'(valid4), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_sel", int'(sel4), 0);
        check("t1_async_gnt", int'(gnt4), 0);
        check("t1_async_valid", int'(valid4), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(7'b0000001);
        check("t1_sel", int'(sel4), 0);
        check("t1_gnt", int'(gnt4), 1);

        // Single persistent requester keeps the mux across hold-limit re-grants
        for (int i = 0; i < 12; i++) begin
            tick(7'b0000100);
            check("t2_sel", int'(sel4), 2);
            check("t2_valid", int'(valid4), 1);
            check("t2_gnt", int'(gnt4), 4);
        end

        // Everyone requesting: rotation in blocks of the hold limit
        do_reset();
        for (int i = 0; i < 32; i++) begin
            tick(7'b1111111);
            check("t3_sel_h4", int'(sel4), (i / 4) % 7);
            check("t3_sel_h1", int'(sel1), i % 7);
            check("t3_valid", int'(valid4), 1);
        end

        // Early drop hands over with no gap
        do_reset();
        tick(7'b0101000);
        check("t4_sel_a", int'(sel4), 3);
        tick(7'b0101000);
        check("t4_sel_b", int'(sel4), 3);
        tick(7'b0100000);
        check("t4_sel_c", int'(sel4), 5);
        check("t4_valid", int'(valid4), 1);
        check("t4_ptr", int'(dut4.ptr_r), 4);

        // Return to idle from owner 6, then pointer wrap to index 0
        do_reset();
        tick(7'b1000000);
        check("t5_sel_own", int'(sel4), 6);
        tick(7'b0000000);
        check("t5_idle_valid", int'(valid4), 0);
        check("t5_idle_gnt", int'(gnt4), 0);
        check("t5_idle_sel", int'(sel4), 6);
        tick(7'b1000001);
        check("t5_wrap_sel", int'(sel4), 0);
        check("t5_wrap_gnt", int'(gnt4), 1);

        // Hold limit 1 alternates between two requesters every cycle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(7'b0100010);
            check("t6_sel", int'(sel1), (i % 2 == 0) ? 1 : 5);
        end

        // Randomized traffic with occasional resets
        r = 7'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       r = 7'd0;
                    1:       r = 7'($urandom);
                    2:       r = 7'($urandom) & 7'($urandom);
                    default: r = 7'd1 << $urandom_range(0, 6);
                endcase
            end
            tick(r);
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
